// File: rtl/paralelo_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : paralelo_serial_pkg
// Description : Shared PHY definitions for the serializer/deserializer pair:
//               comma symbol, byte width, activation comma count and the
//               transmitter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package paralelo_serial_pkg;

    // Comma (COM) symbol. The receiver uses the same value for alignment.
    localparam logic [7:0] COM_SYM            = 8'hBC;
    localparam int         BYTE_W             = 8;
    // Must match the number of commas the receiver waits for before activating.
    localparam int         DEFAULT_MIN_COMMAS = 4;

    typedef enum logic [0:0] {
        ST_INIT   = 1'b0,
        ST_ACTIVE = 1'b1
    } ps_state_t;

endpackage : paralelo_serial_pkg
`default_nettype wire

// File: rtl/paralelo_serial.sv
`default_nettype none
// ============================================================================
// Module      : paralelo_serial
// Description : Transmit-side byte serializer. Takes bytes through a
//               valid/ready handshake and shifts them out MSB-first, one bit
//               per clk_32f. Sends IDLE_SYM whenever no byte is offered and a
//               startup train of MIN_COMMAS IDLE_SYM bytes after reset.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_32f    in   1  bit clock
//   reset_L    in   1  asynchronous active-low reset
//   data_in    in   8  byte to send (bit 7 first)
//   valid_in   in   1  data_in holds a byte to send
//   ready_out  out  1  byte taken at this edge when valid_in is high
//   data_out   out  1  registered serial bit stream
//   active_out out  1  startup comma train complete
// ============================================================================
module paralelo_serial
    import paralelo_serial_pkg::*;
#(
    parameter logic [7:0] IDLE_SYM   = COM_SYM,
    parameter int         MIN_COMMAS = DEFAULT_MIN_COMMAS   // legal 1..15
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              data_out,
    output logic              active_out
);

    localparam logic [3:0] c_MIN_COMMAS = 4'(MIN_COMMAS);
    // With a single required comma the reset byte alone satisfies the train.
    localparam ps_state_t  c_RST_STATE  = (MIN_COMMAS == 1) ? ST_ACTIVE : ST_INIT;

    ps_state_t         r_state;
    logic [2:0]        r_bit_cnt;
    logic [BYTE_W-1:0] r_byte;
    logic [3:0]        r_comma_cnt;
    logic              r_data_out;

    ps_state_t         w_state_nxt;
    logic [BYTE_W-1:0] w_byte_nxt;
    logic [3:0]        w_comma_nxt;
    logic [3:0]        w_comma_inc;
    logic [2:0]        w_bit_idx;
    logic              w_load;

    // MSB first: bit_cnt 0 selects bit 7.
    assign w_bit_idx   = 3'd7 - r_bit_cnt;
    // The LSB of the current byte leaves on the same edge the next byte loads,
    // so the stream has no gap between bytes.
    assign w_load      = (r_bit_cnt == 3'd7);
    assign w_comma_inc = r_comma_cnt + 4'd1;

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= c_RST_STATE;
            r_bit_cnt   <= 3'd0;
            r_byte      <= IDLE_SYM;
            r_comma_cnt <= 4'd1;        // the reset byte is comma #1
            r_data_out  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= r_bit_cnt + 3'd1;
            r_byte      <= w_byte_nxt;
            r_comma_cnt <= w_comma_nxt;
            r_data_out  <= r_byte[w_bit_idx];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = r_byte;
        w_comma_nxt = r_comma_cnt;
        ready_out   = 1'b0;
        active_out  = 1'b0;

        case (r_state)
            ST_INIT: begin
                if (w_load) begin
                    w_byte_nxt  = IDLE_SYM;
                    w_comma_nxt = w_comma_inc;
                    if (w_comma_inc == c_MIN_COMMAS) begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                // Comma counter stays frozen; only reset leaves this state.
                active_out = 1'b1;
                ready_out  = w_load;
                if (w_load) begin
                    w_byte_nxt = valid_in ? data_in : IDLE_SYM;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign data_out = r_data_out;

endmodule : paralelo_serial
`default_nettype wire

// File: tb/tb_paralelo_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_paralelo_serial
// Description : Directed self-checking bench for paralelo_serial.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_paralelo_serial;

    logic       clk_32f;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       active_out;

    int n_cmp;
    int n_err;

    paralelo_serial #(
        .IDLE_SYM   (8'hBC),
        .MIN_COMMAS (4)
    ) u_dut (
        .clk_32f    (clk_32f),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .active_out (active_out)
    );

    initial begin
        clk_32f = 1'b0;
        forever #5 clk_32f = ~clk_32f;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock and settle just after the edge.
    task automatic edge_step();
        @(posedge clk_32f);
        #1;
    endtask

    task automatic test_reset();
        reset_L  = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        #2;
        reset_L = 1'b0;
        #1;
        n_cmp++; if (data_out !== 1'b0)   begin n_err++; $display("FAIL rst_data got=%b exp=0", data_out); end
        n_cmp++; if (ready_out !== 1'b0)  begin n_err++; $display("FAIL rst_ready got=%b exp=0", ready_out); end
        n_cmp++; if (active_out !== 1'b0) begin n_err++; $display("FAIL rst_active got=%b exp=0", active_out); end
        edge_step();
        edge_step();
        n_cmp++; if (data_out !== 1'b0)   begin n_err++; $display("FAIL rst_hold_data got=%b exp=0", data_out); end
        reset_L = 1'b1;   // released just after an edge: next edge is edge 1
    endtask

    // 64 edges with no data: eight commas, activation after the 4th.
    task automatic test_startup();
        logic [7:0] eb;
        logic       er;
        eb = 8'hBC;
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 8; i++) begin
                valid_in = 1'b0;
                er = (s >= 3) && (i == 7);
                n_cmp++; if (ready_out !== er) begin n_err++; $display("FAIL startup_ready s=%0d i=%0d got=%b exp=%b", s, i, ready_out, er); end
                n_cmp++; if (active_out !== (s >= 3)) begin n_err++; $display("FAIL startup_active s=%0d i=%0d got=%b exp=%b", s, i, active_out, (s >= 3)); end
                edge_step();
                n_cmp++; if (data_out !== eb[7-i]) begin n_err++; $display("FAIL startup_bit s=%0d i=%0d got=%b exp=%b", s, i, data_out, eb[7-i]); end
            end
        end
    endtask

    // One byte offered and held until accepted, then dropped.
    task automatic test_single_a5();
        logic [7:0] eb [3];
        logic [7:0] b;
        eb[0] = 8'hBC; eb[1] = 8'hA5; eb[2] = 8'hBC;
        for (int s = 0; s < 3; s++) begin
            b = eb[s];
            for (int i = 0; i < 8; i++) begin
                valid_in = (s == 0);
                data_in  = (s == 0) ? 8'hA5 : 8'h00;
                n_cmp++; if (ready_out !== (i == 7)) begin n_err++; $display("FAIL a5_ready s=%0d i=%0d got=%b exp=%b", s, i, ready_out, (i == 7)); end
                edge_step();
                n_cmp++; if (data_out !== b[7-i]) begin n_err++; $display("FAIL a5_bit s=%0d i=%0d got=%b exp=%b", s, i, data_out, b[7-i]); end
            end
        end
        valid_in = 1'b0;
    endtask

    // Three bytes with valid held continuously: no idle bits between them.
    task automatic test_back_to_back();
        logic [7:0] din [5];
        logic [7:0] eb  [5];
        logic [7:0] b;
        din[0] = 8'h00; din[1] = 8'hFF; din[2] = 8'h3C; din[3] = 8'h00; din[4] = 8'h00;
        eb[0]  = 8'hBC; eb[1]  = 8'h00; eb[2]  = 8'hFF; eb[3]  = 8'h3C; eb[4]  = 8'hBC;
        for (int s = 0; s < 5; s++) begin
            b = eb[s];
            for (int i = 0; i < 8; i++) begin
                valid_in = (s < 3);
                data_in  = din[s];
                n_cmp++; if (ready_out !== (i == 7)) begin n_err++; $display("FAIL b2b_ready s=%0d i=%0d got=%b exp=%b", s, i, ready_out, (i == 7)); end
                edge_step();
                n_cmp++; if (data_out !== b[7-i]) begin n_err++; $display("FAIL b2b_bit s=%0d i=%0d got=%b exp=%b", s, i, data_out, b[7-i]); end
            end
        end
        valid_in = 1'b0;
    endtask

    // Valid raised at bit_cnt==2: the idle byte finishes before 8'h81 goes out.
    task automatic test_late_valid();
        logic [7:0] eb [3];
        logic [7:0] b;
        eb[0] = 8'hBC; eb[1] = 8'h81; eb[2] = 8'hBC;
        for (int s = 0; s < 3; s++) begin
            b = eb[s];
            for (int i = 0; i < 8; i++) begin
                valid_in = (s == 0) && (i >= 2);
                data_in  = 8'h81;
                n_cmp++; if (ready_out !== (i == 7)) begin n_err++; $display("FAIL late_ready s=%0d i=%0d got=%b exp=%b", s, i, ready_out, (i == 7)); end
                edge_step();
                n_cmp++; if (data_out !== b[7-i]) begin n_err++; $display("FAIL late_bit s=%0d i=%0d got=%b exp=%b", s, i, data_out, b[7-i]); end
            end
        end
        valid_in = 1'b0;
    endtask

    // Reset during 8'hA5: output clears at once, comma train restarts,
    // the rest of 8'hA5 never appears.
    task automatic test_reset_mid();
        logic [7:0] eb;
        logic [7:0] a5;
        logic       er;
        eb = 8'hBC;
        a5 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1;
            data_in  = 8'hA5;
            edge_step();
        end
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            n_cmp++; if (data_out !== a5[7-i]) begin n_err++; $display("FAIL mid_a5_bit i=%0d got=%b exp=%b", i, data_out, a5[7-i]); end
        end
        #2;
        reset_L = 1'b0;
        #1;
        n_cmp++; if (data_out !== 1'b0)   begin n_err++; $display("FAIL mid_rst_data got=%b exp=0", data_out); end
        n_cmp++; if (active_out !== 1'b0) begin n_err++; $display("FAIL mid_rst_active got=%b exp=0", active_out); end
        n_cmp++; if (ready_out !== 1'b0)  begin n_err++; $display("FAIL mid_rst_ready got=%b exp=0", ready_out); end
        edge_step();
        edge_step();
        reset_L = 1'b1;
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < 8; i++) begin
                er = (s >= 3) && (i == 7);
                n_cmp++; if (ready_out !== er) begin n_err++; $display("FAIL mid_ready s=%0d i=%0d got=%b exp=%b", s, i, ready_out, er); end
                edge_step();
                n_cmp++; if (data_out !== eb[7-i]) begin n_err++; $display("FAIL mid_bit s=%0d i=%0d got=%b exp=%b", s, i, data_out, eb[7-i]); end
            end
        end
    endtask

    // Valid held during the comma train: 8'h55 follows the 4th comma.
    task automatic test_init_valid();
        logic [7:0] eb [6];
        logic [7:0] b;
        logic       er;
        eb[0] = 8'hBC; eb[1] = 8'hBC; eb[2] = 8'hBC;
        eb[3] = 8'hBC; eb[4] = 8'h55; eb[5] = 8'hBC;
        valid_in = 1'b1;
        data_in  = 8'h55;
        reset_L  = 1'b0;
        edge_step();
        edge_step();
        reset_L = 1'b1;
        for (int s = 0; s < 6; s++) begin
            b = eb[s];
            for (int i = 0; i < 8; i++) begin
                valid_in = (s < 4);
                data_in  = 8'h55;
                er = (s >= 3) && (i == 7);
                n_cmp++; if (ready_out !== er) begin n_err++; $display("FAIL init_ready s=%0d i=%0d got=%b exp=%b", s, i, ready_out, er); end
                edge_step();
                n_cmp++; if (data_out !== b[7-i]) begin n_err++; $display("FAIL init_bit s=%0d i=%0d got=%b exp=%b", s, i, data_out, b[7-i]); end
            end
        end
        valid_in = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_startup();
        test_single_a5();
        test_back_to_back();
        test_late_valid();
        test_reset_mid();
        test_init_valid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_paralelo_serial
`default_nettype wire
